// File: rtl/fetch_stage.sv
// ----------------------------------------------------------------------------
// fetch_stage
//
// Instruction-fetch stage of the 5-stage MIPS pipeline. It owns the program
// counter, the free-running clock-cycle counter and the IF/ID pipeline
// register. instr_mem is read on the falling edge, so imem_data for the
// current pc is stable before the next rising edge and is captured there.
//
// Run-time control, in priority order while running:
//   redirect > halt-detect > stall > advance
// A HALT instruction sitting valid in IF/ID moves the stage into a drain
// phase that injects NOPs for DRAIN_CYCLES edges so the later stages can
// retire. After the drain phase the machine halts until reset.
//
// Optional build macro:
//   FETCH_STATS_EN - adds saturating stall/flush/fetch event counters.
//
// Ports:
//   clock        in   1         system clock, rising-edge active
//   reset        in   1         asynchronous, active-low reset
//   stall        in   1         hold pc and IF/ID this cycle
//   redirect     in   1         taken branch/jump: load redirect_pc, flush IF/ID
//   redirect_pc  in   PC_WIDTH  byte address of redirect target
//   imem_data    in   32        instruction word at address pc
//   pc           out  PC_WIDTH  current fetch byte address
//   cc           out  PC_WIDTH  clock-cycle counter
//   instr        out  32        IF/ID instruction register
//   id_pc        out  PC_WIDTH  address of the instruction held in instr
//   id_valid     out  1         instr is a real fetched instruction
//   halted       out  1         machine halted, high until reset
//   stall_count  out  16        (FETCH_STATS_EN) honoured stall edges
//   flush_count  out  16        (FETCH_STATS_EN) honoured redirect edges
//   fetch_count  out  16        (FETCH_STATS_EN) advance edges
// ----------------------------------------------------------------------------
module fetch_stage #(
    parameter int                  PC_WIDTH     = 16,
    parameter logic [PC_WIDTH-1:0] RESET_PC     = 16'h0000,
    parameter logic [31:0]         HALT_WORD    = 32'hFC000000,
    parameter int                  DRAIN_CYCLES = 3
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                stall,
    input  logic                redirect,
    input  logic [PC_WIDTH-1:0] redirect_pc,
    input  logic [31:0]         imem_data,
    output logic [PC_WIDTH-1:0] pc,
    output logic [PC_WIDTH-1:0] cc,
    output logic [31:0]         instr,
    output logic [PC_WIDTH-1:0] id_pc,
    output logic                id_valid,
`ifdef FETCH_STATS_EN
    output logic [15:0]         stall_count,
    output logic [15:0]         flush_count,
    output logic [15:0]         fetch_count,
`endif
    output logic                halted
);

    localparam logic [1:0] S_RUN   = 2'd0;
    localparam logic [1:0] S_DRAIN = 2'd1;
    localparam logic [1:0] S_HALT  = 2'd2;

    // Drain counter is at least 2 bits and wide enough to hold DRAIN_CYCLES-1.
    localparam int DW = (DRAIN_CYCLES > 4) ? $clog2(DRAIN_CYCLES) : 2;
    localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_CYCLES - 1);

    // Redirect targets are word aligned; the low two address bits are dropped.
    localparam logic [PC_WIDTH-1:0] ALIGN_MASK = ~PC_WIDTH'(3);

    logic [1:0]    state;
    logic [DW-1:0] drain_cnt;

    logic in_run;
    logic do_redirect;
    logic do_halt;
    logic do_stall;
    logic do_advance;

    // Resolve the per-edge action once so the state update and the optional
    // statistics counters agree on exactly which event was honoured.
    always_comb begin
        in_run      = (state == S_RUN);
        do_redirect = 1'b0;
        do_halt     = 1'b0;
        do_stall    = 1'b0;
        do_advance  = 1'b0;
        if (in_run) begin
            if (redirect) begin
                do_redirect = 1'b1;
            end else if (id_valid && (instr == HALT_WORD)) begin
                do_halt = 1'b1;
            end else if (stall) begin
                do_stall = 1'b1;
            end else begin
                do_advance = 1'b1;
            end
        end
    end

    assign halted = (state == S_HALT);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= S_RUN;
            drain_cnt <= '0;
            pc        <= RESET_PC;
            cc        <= '0;
            instr     <= 32'h00000000;
            id_pc     <= '0;
            id_valid  <= 1'b0;
        end else begin
            // The cycle counter keeps running through stalls and the drain
            // phase so software can measure the full retire time.
            if (state != S_HALT) begin
                cc <= cc + PC_WIDTH'(1);
            end

            case (state)
                S_RUN: begin
                    if (do_redirect) begin
                        pc       <= redirect_pc & ALIGN_MASK;
                        instr    <= 32'h00000000;
                        id_valid <= 1'b0;
                    end else if (do_halt) begin
                        state     <= S_DRAIN;
                        drain_cnt <= DRAIN_LOAD;
                        instr     <= 32'h00000000;
                        id_valid  <= 1'b0;
                    end else if (do_advance) begin
                        instr    <= imem_data;
                        id_pc    <= pc;
                        id_valid <= 1'b1;
                        pc       <= pc + PC_WIDTH'(4);
                    end
                end
                S_DRAIN: begin
                    instr    <= 32'h00000000;
                    id_valid <= 1'b0;
                    if (drain_cnt == '0) begin
                        state <= S_HALT;
                    end else begin
                        drain_cnt <= drain_cnt - DW'(1);
                    end
                end
                default: begin
                    state <= S_HALT;
                end
            endcase
        end
    end

`ifdef FETCH_STATS_EN
    // Event counters saturate rather than wrap so a long run never reports
    // a misleadingly small value. They only move while running.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stall_count <= '0;
            flush_count <= '0;
            fetch_count <= '0;
        end else begin
            if (do_stall && (stall_count != 16'hFFFF)) begin
                stall_count <= stall_count + 16'd1;
            end
            if (do_redirect && (flush_count != 16'hFFFF)) begin
                flush_count <= flush_count + 16'd1;
            end
            if (do_advance && (fetch_count != 16'hFFFF)) begin
                fetch_count <= fetch_count + 16'd1;
            end
        end
    end
`endif

endmodule
